// File: rtl/inst_buffer.sv
// Dual-ported instruction queue between decode and the dual-issue dispatcher.
// Optional perf counters (perf_empty/perf_full) are enabled by defining IBUF_PERF_EN.
module inst_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       in_valid0,
  input  logic                       in_valid1,
  input  logic [WIDTH-1:0]           in_data0,
  input  logic [WIDTH-1:0]           in_data1,
  output logic                       in_ready,
  output logic                       out_valid0,
  output logic                       out_valid1,
  output logic [WIDTH-1:0]           out_data0,
  output logic [WIDTH-1:0]           out_data1,
  input  logic [1:0]                 issue_num,
`ifdef IBUF_PERF_EN
  output logic [31:0]                perf_empty,
  output logic [31:0]                perf_full,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [CW-1:0]    count_r;

  logic             ready_s;
  logic             push0_s;
  logic             push1_s;
  logic [1:0]       n_push_s;
  logic [1:0]       issue_eff_s;
  logic [1:0]       n_pop_s;
  logic [AW-1:0]    head_p1_s;
  logic [AW-1:0]    tail_p1_s;

  assign ready_s   = (count_r <= CW'(DEPTH - 2));
  assign head_p1_s = head_r + AW'(1);
  assign tail_p1_s = tail_r + AW'(1);

  // Push/pop amounts; a lone in_valid1 is illegal and pushes nothing.
  always_comb begin
    push0_s     = 1'b0;
    push1_s     = 1'b0;
    issue_eff_s = 2'd0;
    n_pop_s     = 2'd0;
    if (ready_s && in_valid0) begin
      push0_s = 1'b1;
      push1_s = in_valid1;
    end else begin
      push0_s = 1'b0;
      push1_s = 1'b0;
    end
    case (issue_num)
      2'd0:    issue_eff_s = 2'd0;
      2'd1:    issue_eff_s = 2'd1;
      2'd2:    issue_eff_s = 2'd2;
      2'd3:    issue_eff_s = 2'd2;
      default: issue_eff_s = 2'd0;
    endcase
    if (stall) begin
      n_pop_s = 2'd0;
    end else if (CW'(issue_eff_s) > count_r) begin
      n_pop_s = count_r[1:0];
    end else begin
      n_pop_s = issue_eff_s;
    end
  end

  assign n_push_s = {1'b0, push0_s} + {1'b0, push1_s};

  // Pointer and occupancy state; flush discards same-cycle pushes and pops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + AW'(n_pop_s);
      tail_r  <= tail_r + AW'(n_push_s);
      count_r <= count_r + CW'(n_push_s) - CW'(n_pop_s);
    end
  end

  // Bundle storage; contents are never cleared, only the pointers.
  always_ff @(posedge clk) begin
    if (rstn && !flush) begin
      if (push0_s) begin
        mem_r[tail_r] <= in_data0;
      end
      if (push1_s) begin
        mem_r[tail_p1_s] <= in_data1;
      end
    end
  end

  // Read ports follow the zeroed-slot convention for empty slots.
  always_comb begin
    out_valid0 = (count_r >= CW'(1));
    out_valid1 = (count_r >= CW'(2));
    if (out_valid0) begin
      out_data0 = mem_r[head_r];
    end else begin
      out_data0 = '0;
    end
    if (out_valid1) begin
      out_data1 = mem_r[head_p1_s];
    end else begin
      out_data1 = '0;
    end
  end

  assign in_ready = ready_s;
  assign count    = count_r;

`ifdef IBUF_PERF_EN
  logic [31:0] perf_empty_r;
  logic [31:0] perf_full_r;

  // Saturating occupancy counters, immune to flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_empty_r <= 32'd0;
      perf_full_r  <= 32'd0;
    end else begin
      if ((count_r == CW'(0)) && !flush && (perf_empty_r != 32'hFFFF_FFFF)) begin
        perf_empty_r <= perf_empty_r + 32'd1;
      end
      if (!ready_s && (perf_full_r != 32'hFFFF_FFFF)) begin
        perf_full_r <= perf_full_r + 32'd1;
      end
    end
  end

  assign perf_empty = perf_empty_r;
  assign perf_full  = perf_full_r;
`endif

endmodule
